insn_dispatcher: RTL

INSN_DISPATCHER -- requirements
Module: insn_dispatcher

---
 rtl/insn_dispatcher.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/insn_dispatcher.sv
// -----------------------------------------------------------------------------
// insn_dispatcher
//
// Single-entry skid buffer between the vector decoder and the vector functional
// units (VFUs). A decoded instruction is accepted into the hold register. It is
// shown to the scoreboard on hold_data_o. It is dispatched to its target VFU
// once the scoreboard reports no hazard and a free instruction ID exists. Each
// issued instruction takes the lowest free ID from a bitmap pool. VFUs return
// the ID through their completion pulses.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_*              decoder valid/ready handshake (payload + target VFU)
//   hold_data_o        buffered instruction offered for the hazard check
//   stall_i            scoreboard hazard stall for the buffered instruction
//   issue_gnt_o        one-cycle pulse when the buffered instruction issues
//   issue_id_o         ID allocated to the issuing instruction
//   vfu_valid_o        one-hot dispatch valid, vfu_ready_i per-VFU ready
//   vfu_data_o         payload to the VFUs (same as hold_data_o)
//   insn_done_i        per-VFU completion pulse with its ID on insn_done_id_i
//   outstanding_o      number of currently allocated IDs
//   busy_o             buffer occupied or IDs outstanding
//   stall_cycles_o     saturating count of cycles the buffer was blocked
// -----------------------------------------------------------------------------
module insn_dispatcher #(
    parameter int unsigned NrVFU     = 4,
    parameter int unsigned InsnIDNum = 8,
    parameter int unsigned DataWidth = 64,
    localparam int unsigned VfuW     = (NrVFU > 1) ? $clog2(NrVFU) : 1,
    localparam int unsigned IDW      = (InsnIDNum > 1) ? $clog2(InsnIDNum) : 1,
    localparam int unsigned CntW     = $clog2(InsnIDNum + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [DataWidth-1:0]   req_data_i,
    input  logic [VfuW-1:0]        req_vfu_i,
    output logic [DataWidth-1:0]   hold_data_o,
    input  logic                   stall_i,
    output logic                   issue_gnt_o,
    output logic [IDW-1:0]         issue_id_o,
    output logic [NrVFU-1:0]       vfu_valid_o,
    input  logic [NrVFU-1:0]       vfu_ready_i,
    output logic [DataWidth-1:0]   vfu_data_o,
    input  logic [NrVFU-1:0]       insn_done_i,
    input  logic [NrVFU*IDW-1:0]   insn_done_id_i,
    output logic [CntW-1:0]        outstanding_o,
    output logic                   busy_o,
    output logic [15:0]            stall_cycles_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_e                 state_q, state_d;
    logic [InsnIDNum-1:0]   pool_q, pool_d;
    logic [DataWidth-1:0]   hold_data_q;
    logic [VfuW-1:0]        hold_vfu_q;
    logic [15:0]            stall_cnt_q;
    logic                   id_avail;
    logic [IDW-1:0]         free_id;
    logic [NrVFU-1:0]       vfu_valid;
    logic                   fire;
    logic                   accept;
    logic                   blocked;
    logic [CntW-1:0]        pool_cnt;

    // ---- ID pool lookup: lowest free ID ----
    assign id_avail = |(~pool_q);

    always_comb begin
        free_id = '0;
        for (int i = int'(InsnIDNum) - 1; i >= 0; i--) begin
            if (!pool_q[i]) free_id = IDW'(i);
        end
    end

    // ---- Dispatch: valid never looks at ready, so no comb path ready->valid ----
    always_comb begin
        vfu_valid = '0;
        if (state_q == HOLD && !stall_i && id_avail) vfu_valid[hold_vfu_q] = 1'b1;
    end

    assign fire    = vfu_valid[hold_vfu_q] & vfu_ready_i[hold_vfu_q];
    assign accept  = req_valid_i & req_ready_o;
    assign blocked = (state_q == HOLD) && (stall_i || !id_avail);

    // ---- FSM: state register ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= EMPTY;
        else         state_q <= state_d;
    end

    // ---- FSM: next state (fire + accept in the same cycle stays in HOLD) ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = HOLD;
            HOLD:    if (fire && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // ---- FSM: outputs (ready also when the held entry drains this cycle) ----
    always_comb begin
        req_ready_o = (state_q == EMPTY) || fire;
    end

    // ---- Hold register: payload needs no reset, state qualifies it ----
    always_ff @(posedge clk_i) begin
        if (accept) begin
            hold_data_q <= req_data_i;
            hold_vfu_q  <= req_vfu_i;
        end
    end

    // ---- Pool update: completions clear, then the issue sets ----
    // A completion naming an unallocated ID clears a bit that is already 0, so
    // it is ignored. That includes the ID being issued this very cycle, because
    // the set is applied after the clears.
    always_comb begin
        pool_d = pool_q;
        for (int i = 0; i < int'(NrVFU); i++) begin
            if (insn_done_i[i]) pool_d[insn_done_id_i[i*IDW +: IDW]] = 1'b0;
        end
        if (fire) pool_d[free_id] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pool_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            pool_q <= pool_d;
            if (blocked) stall_cnt_q <= sat_inc16(stall_cnt_q);
        end
    end

    // outstanding is the popcount of the registered pool: +fire and -valid
    // completions land in the pool on the same edge.
    always_comb begin
        pool_cnt = '0;
        for (int i = 0; i < int'(InsnIDNum); i++) pool_cnt = pool_cnt + CntW'(pool_q[i]);
    end

    assign hold_data_o    = hold_data_q;
    assign vfu_data_o     = hold_data_q;
    assign vfu_valid_o    = vfu_valid;
    assign issue_gnt_o    = fire;
    assign issue_id_o     = free_id;
    assign outstanding_o  = pool_cnt;
    assign busy_o         = (state_q == HOLD) || (pool_q != '0);
    assign stall_cycles_o = stall_cnt_q;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) begin
            for (int i = 0; i < int'(NrVFU); i++) begin
                if (insn_done_i[i]) begin
                    assert (pool_q[insn_done_id_i[i*IDW +: IDW]])
                    else $error("completion for unallocated instruction ID");
                end
            end
        end
    end
`endif

endmodule
